// File: rtl/miriscv_mem_arbiter.sv
// Memory arbiter for the miriscv core: shares one single-ported,
// single-outstanding memory between instruction fetch and the LSU.
// Data has priority over fetch; a burst counter forces a waiting fetch
// through after MAX_DATA_BURST consecutive data grants.
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | no transaction outstanding, arbitration and issue allowed
// WAIT_I | instruction fetch outstanding, waiting for mem_rvalid_i
// WAIT_D | data access outstanding, waiting for mem_rvalid_i
module miriscv_mem_arbiter #(
  parameter int XLEN           = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic              clk_i,
  input  logic              arstn_i,

  input  logic              instr_req_i,
  input  logic [XLEN-1:0]   instr_addr_i,
  input  logic              instr_kill_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  output logic [XLEN-1:0]   instr_rdata_o,

  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [XLEN/8-1:0] data_be_i,
  input  logic [XLEN-1:0]   data_addr_i,
  input  logic [XLEN-1:0]   data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [XLEN-1:0]   data_rdata_o,

  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_addr_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i,

  output logic              spurious_rvalid_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_e;

  localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

  state_e     state_q, state_d;
  logic [3:0] burst_q, burst_d;
  logic       drop_q,  drop_d;
  logic       instr_win;
  logic       data_win;

  // Read data is a plain pass-through; it is only meaningful with rvalid.
  assign instr_rdata_o = mem_rdata_i;
  assign data_rdata_o  = mem_rdata_i;

  // State, burst counter and drop flag registers.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q <= IDLE;
      burst_q <= 4'd0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      drop_q  <= drop_d;
    end
  end

  // Arbitration, memory port drive, response routing and next state.
  always_comb begin
    state_d           = state_q;
    burst_d           = burst_q;
    drop_d            = drop_q;
    instr_win         = 1'b0;
    data_win          = 1'b0;
    instr_gnt_o       = 1'b0;
    data_gnt_o        = 1'b0;
    instr_rvalid_o    = 1'b0;
    data_rvalid_o     = 1'b0;
    spurious_rvalid_o = 1'b0;
    mem_req_o         = 1'b0;
    mem_we_o          = 1'b0;
    mem_be_o          = '0;
    mem_addr_o        = '0;
    mem_wdata_o       = '0;

    case (state_q)
      IDLE: begin
        // A fetch wins only when alone or when data has used up its burst.
        instr_win         = instr_req_i & (~data_req_i | (burst_q == BURST_MAX));
        data_win          = data_req_i & ~instr_win;
        spurious_rvalid_o = mem_rvalid_i;
        if (instr_win) begin
          instr_gnt_o = 1'b1;
          mem_req_o   = 1'b1;
          mem_be_o    = '1;
          mem_addr_o  = instr_addr_i;
          burst_d     = 4'd0;
          drop_d      = instr_kill_i;
          state_d     = WAIT_I;
        end else if (data_win) begin
          data_gnt_o  = 1'b1;
          mem_req_o   = 1'b1;
          mem_we_o    = data_we_i;
          mem_be_o    = data_be_i;
          mem_addr_o  = data_addr_i;
          mem_wdata_o = data_wdata_i;
          if (!instr_req_i) begin
            burst_d = 4'd0;
          end else if (burst_q != BURST_MAX) begin
            burst_d = burst_q + 4'd1;
          end
          state_d = WAIT_D;
        end
      end
      WAIT_I: begin
        if (instr_kill_i) begin
          drop_d = 1'b1;
        end
        if (mem_rvalid_i) begin
          instr_rvalid_o = ~drop_q & ~instr_kill_i;
          drop_d         = 1'b0;
          state_d        = IDLE;
        end
      end
      WAIT_D: begin
        if (mem_rvalid_i) begin
          data_rvalid_o = 1'b1;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Reset forces every handshake and port output quiet.
    if (!arstn_i) begin
      instr_gnt_o       = 1'b0;
      data_gnt_o        = 1'b0;
      instr_rvalid_o    = 1'b0;
      data_rvalid_o     = 1'b0;
      spurious_rvalid_o = 1'b0;
      mem_req_o         = 1'b0;
      mem_we_o          = 1'b0;
      mem_be_o          = '0;
      mem_addr_o        = '0;
      mem_wdata_o       = '0;
    end
  end

endmodule

// File: tb/tb_miriscv_mem_arbiter.sv
// Self-checking bench for miriscv_mem_arbiter: transaction-level reference
// model plus directed scenarios and a randomized traffic run.
module tb_miriscv_mem_arbiter;

  localparam int XLEN = 32;
  localparam int MAXB = 4;

  logic            clk_i = 1'b0;
  logic            arstn_i;
  logic            instr_req_i, instr_kill_i, instr_gnt_o, instr_rvalid_o;
  logic [XLEN-1:0] instr_addr_i, instr_rdata_o;
  logic            data_req_i, data_we_i, data_gnt_o, data_rvalid_o;
  logic [3:0]      data_be_i;
  logic [XLEN-1:0] data_addr_i, data_wdata_i, data_rdata_o;
  logic            mem_req_o, mem_we_o, mem_rvalid_i, spurious_rvalid_o;
  logic [3:0]      mem_be_o;
  logic [XLEN-1:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  miriscv_mem_arbiter #(.XLEN(XLEN), .MAX_DATA_BURST(MAXB)) dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i), .instr_kill_i(instr_kill_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o), .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .spurious_rvalid_o(spurious_rvalid_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: one outstanding transaction, its owner, cycles left
  // until the memory answers, whether a fetch answer must be dropped, and
  // how many data grants in a row went through while a fetch was waiting.
  bit m_busy;
  bit m_own_i;
  int m_cnt;
  bit m_drop;
  int m_burst;
  bit spur_inj;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_own_i = 1'b0;
    m_cnt   = 0;
    m_drop  = 1'b0;
    m_burst = 0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_gnt"}, 32'({instr_gnt_o, data_gnt_o}), 32'd0);
    check({tag, "_rvalid"}, 32'({instr_rvalid_o, data_rvalid_o, spurious_rvalid_o}), 32'd0);
    check({tag, "_mem_ctl"}, 32'({mem_req_o, mem_we_o, mem_be_o}), 32'd0);
    check({tag, "_mem_addr"}, mem_addr_o, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata_o, 32'd0);
  endtask

  // One clock cycle: entered at posedge+1 with requester inputs set; plays
  // memory, checks outputs at the falling edge, advances the model.
  task automatic step(input int lat, output bit got_i, output bit got_d);
    bit rv, eig, edg;
    logic [31:0] rd;
    rv  = m_busy && (m_cnt == 1);
    rd  = $urandom;
    mem_rvalid_i = rv | spur_inj;
    mem_rdata_i  = rd;
    eig = 1'b0;
    edg = 1'b0;
    if (!m_busy) begin
      if (instr_req_i && (!data_req_i || m_burst == MAXB)) eig = 1'b1;
      else if (data_req_i) edg = 1'b1;
    end
    #4;
    check("instr_gnt", 32'(instr_gnt_o), 32'(eig));
    check("data_gnt", 32'(data_gnt_o), 32'(edg));
    check("mem_req", 32'(mem_req_o), 32'(eig | edg));
    if (eig) begin
      check("i_mem_addr", mem_addr_o, instr_addr_i);
      check("i_mem_we_be", 32'({mem_we_o, mem_be_o}), 32'h0F);
      check("i_mem_wdata", mem_wdata_o, 32'd0);
    end
    if (edg) begin
      check("d_mem_addr", mem_addr_o, data_addr_i);
      check("d_mem_we_be", 32'({mem_we_o, mem_be_o}), 32'({data_we_i, data_be_i}));
      check("d_mem_wdata", mem_wdata_o, data_wdata_i);
    end
    check("instr_rvalid", 32'(instr_rvalid_o), 32'(rv && m_own_i && !m_drop && !instr_kill_i));
    check("data_rvalid", 32'(data_rvalid_o), 32'(rv && !m_own_i));
    check("spurious", 32'(spurious_rvalid_o), 32'(mem_rvalid_i && !m_busy));
    if (rv && m_own_i) check("instr_rdata", instr_rdata_o, rd);
    if (rv && !m_own_i) check("data_rdata", data_rdata_o, rd);

    if (m_busy) begin
      if (rv) begin
        m_busy = 1'b0;
        m_drop = 1'b0;
      end else begin
        if (m_own_i && instr_kill_i) m_drop = 1'b1;
        m_cnt--;
      end
    end else if (eig) begin
      m_busy  = 1'b1;
      m_own_i = 1'b1;
      m_cnt   = lat;
      m_drop  = instr_kill_i;
      m_burst = 0;
    end else if (edg) begin
      m_busy  = 1'b1;
      m_own_i = 1'b0;
      m_cnt   = lat;
      m_burst = instr_req_i ? ((m_burst + 1 > MAXB) ? MAXB : m_burst + 1) : 0;
    end
    got_i = eig;
    got_d = edg;
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    arstn_i = 1'b0;
    instr_req_i = 1'b0; instr_kill_i = 1'b0; data_req_i = 1'b0;
    mem_rvalid_i = 1'b0;
    @(posedge clk_i);
    #1;
    arstn_i = 1'b1;
    model_reset();
  endtask

  initial begin
    bit gi, gd;
    logic [2:0] fseq;
    logic [9:0] order;
    int ng;

    spur_inj = 1'b0;
    model_reset();
    arstn_i = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 32'h100; instr_kill_i = 1'b0;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
    data_addr_i = 32'h8000; data_wdata_i = 32'hDEADBEEF;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h13;
    #3;
    check_quiet("reset");
    do_reset();

    // Fetch alone, latency 1: grant, response, grant again.
    instr_req_i = 1'b1; instr_addr_i = 32'h100;
    step(1, gi, gd); fseq[2] = gi;
    step(1, gi, gd); fseq[1] = gi;
    instr_addr_i = 32'h104;
    step(1, gi, gd); fseq[0] = gi;
    check("fetch_grant_seq", 32'(fseq), 32'b101);
    step(1, gi, gd);
    instr_req_i = 1'b0;

    // Simultaneous instr and data store: data first, then instr after response.
    instr_req_i = 1'b1; instr_addr_i = 32'h200;
    data_req_i = 1'b1; data_we_i = 1'b1; data_be_i = 4'hF;
    data_addr_i = 32'h8000; data_wdata_i = 32'hDEADBEEF;
    step(2, gi, gd); check("simul_first_is_data", 32'({gi, gd}), 32'b01);
    data_req_i = 1'b0;
    step(2, gi, gd);
    step(2, gi, gd);
    step(2, gi, gd); check("simul_then_instr", 32'({gi, gd}), 32'b10);
    instr_req_i = 1'b0;
    step(2, gi, gd);
    step(2, gi, gd);

    // Starvation guard with both requesters held high.
    do_reset();
    instr_req_i = 1'b1; data_req_i = 1'b1; data_we_i = 1'b0;
    order = '0;
    ng = 0;
    for (int c = 0; c < 40 && ng < 10; c++) begin
      step(1, gi, gd);
      if (gi || gd) begin
        order[9 - ng] = gi;
        ng++;
      end
    end
    check("starve_order", 32'(order), 32'b0000100001);
    instr_req_i = 1'b0; data_req_i = 1'b0;

    // Kill mid-fetch, latency 3, then branch-target fetch the next cycle.
    do_reset();
    instr_req_i = 1'b1; instr_addr_i = 32'h300;
    step(3, gi, gd);
    instr_req_i = 1'b0; instr_kill_i = 1'b1;
    step(3, gi, gd);
    instr_kill_i = 1'b0;
    step(3, gi, gd);
    step(3, gi, gd);
    instr_req_i = 1'b1; instr_addr_i = 32'h400;
    step(1, gi, gd); check("kill_then_target_gnt", 32'(gi), 32'd1);
    instr_req_i = 1'b0;
    step(1, gi, gd);

    // Kill in the grant cycle, then kill in the response cycle.
    instr_req_i = 1'b1; instr_addr_i = 32'h500; instr_kill_i = 1'b1;
    step(2, gi, gd);
    instr_req_i = 1'b0; instr_kill_i = 1'b0;
    step(2, gi, gd);
    step(2, gi, gd);
    instr_req_i = 1'b1; instr_addr_i = 32'h600;
    step(1, gi, gd);
    instr_req_i = 1'b0; instr_kill_i = 1'b1;
    step(1, gi, gd);
    instr_kill_i = 1'b0;

    // Kill during WAIT_D leaves the data response alone.
    data_req_i = 1'b1; data_we_i = 1'b0; data_addr_i = 32'h9000;
    step(2, gi, gd);
    data_req_i = 1'b0; instr_kill_i = 1'b1;
    step(2, gi, gd);
    step(2, gi, gd);
    instr_kill_i = 1'b0;

    // Reset during WAIT_D; late response after release is spurious only.
    data_req_i = 1'b1; data_we_i = 1'b1; data_addr_i = 32'hA000;
    step(5, gi, gd);
    arstn_i = 1'b0; instr_req_i = 1'b1; mem_rvalid_i = 1'b1;
    #2;
    check_quiet("reset_wait_d");
    instr_req_i = 1'b0; data_req_i = 1'b0; mem_rvalid_i = 1'b0;
    @(posedge clk_i);
    #1;
    arstn_i = 1'b1;
    model_reset();
    spur_inj = 1'b1;
    step(1, gi, gd);
    spur_inj = 1'b0;
    step(1, gi, gd);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      if (!instr_req_i && $urandom_range(0, 2) != 0) begin
        instr_req_i  = 1'b1;
        instr_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if (!data_req_i && $urandom_range(0, 2) != 0) begin
        data_req_i   = 1'b1;
        data_we_i    = 1'($urandom_range(0, 1));
        data_be_i    = 4'($urandom_range(1, 15));
        data_addr_i  = $urandom;
        data_wdata_i = $urandom;
      end
      instr_kill_i = ($urandom_range(0, 7) == 0);
      step($urandom_range(1, 4), gi, gd);
      if (gi) instr_req_i = 1'b0;
      if (gd) data_req_i = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
